nios2_oci_dct_monitor: RTL and testbench
========================================

# nios2_oci_dct_monitor

Parametrised trace-capture monitor for the Nios II on-chip-instrumentation (OCI) direct-control-transfer (DCT) stream. It snapshots `{dct_count, dct_buffer}` into an on-chip FIFO, counts dropped snapshots, and sequences a clean end-of-test drain driven by `test_ending` / `test_has_ended`. It sits beside the OCI block in simulation and debug builds. A host-side reader pulls records through a valid/ready port.

## Interface

Parameters:
- `DCT_W`, 30: width of `dct_buffer`.
- `CNT_W`, 4: width of `dct_count`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `OVF_W`, 16: width of the overflow counter.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dct_buffer`  in  DCT_W  DCT fragment bits.
- `dct_count`  in  CNT_W  number of valid fragments in `dct_buffer`.
- `dct_valid`  in  1  snapshot strobe.
- `test_ending`  in  1  test is finishing; level or pulse.
- `test_has_ended`  in  1  test finished; level or pulse.
- `rd_ready`  in  1  reader accepts the head record.
- `rd_valid`  out  1  head record available (FIFO not empty).
- `rd_data`  out  CNT_W+DCT_W  `{dct_count, dct_buffer}` of the head record; 0 when `rd_valid`=0.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_cnt`  out  OVF_W  dropped snapshots; saturating.
- `state`  out  2  0=RUN, 1=ENDING, 2=DRAIN, 3=DONE.
- `drained`  out  1  high only in DONE.

## Operation

- **Capture request:** `dct_valid`=1 and `dct_count`≠0 and state ∈ {RUN, ENDING}.
  - Zero-count snapshots are ignored; they do not count as overflow.
  - Requests in DRAIN or DONE are ignored silently.
- **Pop:** `rd_valid` & `rd_ready`. A pop on an empty FIFO is a no-op.
- **Write when full:**
  - Accepted if a pop occurs in the same cycle; `level` stays DEPTH.
  - Otherwise dropped, and `overflow_cnt` increments, saturating at 2^OVF_W−1.
- **Simultaneous push and pop:** `level` is unchanged; FIFO order is preserved.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `level`.
- **State machine** (transitions are evaluated every cycle):
  - RUN → ENDING on `test_ending`=1 and `test_has_ended`=0.
  - RUN → DRAIN on `test_has_ended`=1, regardless of `test_ending`.
  - ENDING → DRAIN on `test_has_ended`=1.
  - DRAIN → DONE when `level`=0 after this cycle's pop, including entering DRAIN with an empty FIFO (one cycle in DRAIN minimum).
  - DONE holds until `reset`. Further `test_*` pulses are ignored.
- **Drain boundary:** a capture presented in the same cycle `test_has_ended` first rises is still accepted, because the state is still RUN/ENDING in that cycle.
- **Reset:** synchronous, and takes effect mid-operation (including mid-drain).
  - Values after reset: `state`=RUN, `level`=0, pointers=0, `overflow_cnt`=0, `rd_valid`=0, `rd_data`=0, `drained`=0.
  - FIFO storage is not cleared.

## Timing

- Push latency: a record captured at edge N gives `rd_valid`=1 and `rd_data` valid after edge N; `level` increments at the same edge.
- Show-ahead read: `rd_data` is the head whenever `rd_valid`=1, with no read latency. A pop at edge N presents the next record after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `state`, `drained`, `level` and `overflow_cnt` are registered and update on the same edge as the event that causes them.
- No combinational path from `dct_*` to `rd_*` within a cycle.

## Test plan

- **Reset state:** assert `reset` 2 cycles -> all outputs at reset values; `state`=0; `level`=0.
- **Push, then pop in order:** push 3 records (count=1,2,3; buffer=0x1, 0x2, 0x3) with `rd_ready`=0 -> `level`=3. Then `rd_ready`=1 -> records pop in order, one per cycle; `rd_valid` falls after the 3rd pop.
- **Overflow and saturation:**
  - DEPTH=16, `rd_ready`=0, 20 valid pushes -> `level`=16, `overflow_cnt`=4.
  - Push and pop together while full -> accepted; `overflow_cnt` stays 4.
  - With OVF_W=2, 5 drops -> `overflow_cnt`=3.
- **Zero count and drain:** `dct_count`=0 with `dct_valid`=1 -> `level` unchanged. Then `test_ending`, then `test_has_ended` with 2 records queued -> state goes 0→1→2; pushes in DRAIN are ignored; after 2 pops, `state`=3 and `drained`=1.
- **Simultaneous events:**
  - `test_ending` and `test_has_ended` together in RUN with an empty FIFO -> DRAIN for one cycle, then DONE.
  - A capture in the `test_has_ended` cycle is accepted.
- **Wrap and mid-drain reset:** 40 push/pop pairs with incrementing data -> data order is exact across pointer wrap. Then `reset` mid-DRAIN -> RUN, `level`=0, `overflow_cnt`=0 the next cycle.

Source files
------------

// File: rtl/nios2_oci_dct_monitor.sv
// nios2_oci_dct_monitor
// Captures {dct_count, dct_buffer} snapshots from the Nios II OCI DCT stream
// into a show-ahead FIFO, counts dropped snapshots, and sequences an
// end-of-test drain (RUN -> ENDING -> DRAIN -> DONE).
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   dct_buffer/dct_count  snapshot payload
//   dct_valid             snapshot strobe
//   test_ending           test finishing (level or pulse)
//   test_has_ended        test finished (level or pulse)
//   rd_ready              reader accepts head record
//   rd_valid/rd_data      head record (rd_data is 0 when empty)
//   level                 FIFO occupancy 0..DEPTH
//   overflow_cnt          saturating count of dropped snapshots
//   state                 0=RUN 1=ENDING 2=DRAIN 3=DONE
//   drained               high only in DONE
module nios2_oci_dct_monitor #(
  parameter int unsigned DCT_W = 30,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned OVF_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DCT_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       dct_valid,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CNT_W+DCT_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic [1:0]                 state,
  output logic                       drained
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = CNT_W + DCT_W;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic [OVF_W-1:0] r_ovf;
  logic            r_drained;

  logic w_cap;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // Capture only while the test is still producing trace.
  assign w_cap  = dct_valid && (dct_count != '0) &&
                  ((r_state == ST_RUN) || (r_state == ST_ENDING));
  assign w_pop  = (r_level != '0) && rd_ready;
  assign w_full = (r_level == LW'(DEPTH));
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Next-state logic for the end-of-test sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (test_has_ended) begin
          w_state_nxt = ST_DRAIN;
        end else if (test_ending) begin
          w_state_nxt = ST_ENDING;
        end
      end
      ST_ENDING: begin
        if (test_has_ended) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_level_nxt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_DONE;
    endcase
  end

  // State, pointers, occupancy and overflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf     <= '0;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_drained <= (w_state_nxt == ST_DONE);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_drop && !(&r_ovf)) begin
        r_ovf <= r_ovf + OVF_W'(1);
      end
    end
  end

  // Storage is intentionally not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  assign rd_valid     = (r_level != '0);
  assign rd_data      = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign level        = r_level;
  assign overflow_cnt = r_ovf;
  assign state        = r_state;
  assign drained      = r_drained;

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
module tb_nios2_oci_dct_monitor;

  localparam int unsigned DCT_W = 30;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OVF_W = 16;
  localparam int unsigned DW    = CNT_W + DCT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic             reset, dct_valid, test_ending, test_has_ended, rd_ready;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             rd_valid, drained;
  logic [DW-1:0]    rd_data;
  logic [4:0]       level;
  logic [15:0]      overflow_cnt;
  logic [1:0]       state;

  // Small instance for saturation (DEPTH=2, OVF_W=2)
  logic             b_reset, b_dct_valid, b_test_ending, b_test_has_ended, b_rd_ready;
  logic [DCT_W-1:0] b_dct_buffer;
  logic [CNT_W-1:0] b_dct_count;
  logic             b_rd_valid, b_drained;
  logic [DW-1:0]    b_rd_data;
  logic [1:0]       b_level;
  logic [1:0]       b_overflow_cnt;
  logic [1:0]       b_state;

  nios2_oci_dct_monitor #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .overflow_cnt(overflow_cnt), .state(state), .drained(drained)
  );

  nios2_oci_dct_monitor #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(2), .OVF_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .dct_buffer(b_dct_buffer), .dct_count(b_dct_count),
    .dct_valid(b_dct_valid), .test_ending(b_test_ending), .test_has_ended(b_test_has_ended),
    .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .level(b_level),
    .overflow_cnt(b_overflow_cnt), .state(b_state), .drained(b_drained)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of records plus a state number.
  logic [DW-1:0] mq[$];
  int            m_ovf;
  int            m_state;

  task automatic model_step();
    bit cap, pop;
    if (reset) begin
      mq.delete();
      m_ovf   = 0;
      m_state = 0;
    end else begin
      cap = dct_valid && (dct_count != 0) && (m_state < 2);
      pop = rd_ready && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back({dct_count, dct_buffer});
        else if (m_ovf < 65535) m_ovf++;
      end
      case (m_state)
        0: if (test_has_ended) m_state = 2; else if (test_ending) m_state = 1;
        1: if (test_has_ended) m_state = 2;
        2: if (mq.size() == 0) m_state = 3;
        default: ;
      endcase
    end
  endtask

  function automatic logic [DW-1:0] exp_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; dct_valid = 0; dct_count = '0; dct_buffer = '0;
    test_ending = 0; test_has_ended = 0; rd_ready = 0;
    b_reset = 0; b_dct_valid = 0; b_dct_count = '0; b_dct_buffer = '0;
    b_test_ending = 0; b_test_has_ended = 0; b_rd_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; b_reset = 1;
    dct_valid = 1; dct_count = 4'd7; dct_buffer = 30'h155;
    tick();
    tick();
    idle_inputs();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %0b expected 0", drained); end
    checks++; if (b_level !== 2'd0 || b_overflow_cnt !== 2'd0) begin errors++;
      $display("FAIL reset_b: got level %0d ovf %0d expected 0 0", b_level, b_overflow_cnt); end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      dct_valid = 1; dct_count = CNT_W'(i); dct_buffer = DCT_W'(i);
      tick();
    end
    dct_valid = 0;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL push_level: got %0d expected 3", level); end
    rd_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      exp = {CNT_W'(i), DCT_W'(i)};
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin errors++;
        $display("FAIL pop_order_%0d: got valid %0b data %h expected 1 %h", i, rd_valid, rd_data, exp); end
      tick();
    end
    checks++; if (rd_valid !== 1'b0 || level !== 5'd0) begin errors++;
      $display("FAIL pop_empty: got valid %0b level %0d expected 0 0", rd_valid, level); end
    rd_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      dct_valid = 1; dct_count = CNT_W'($urandom_range(1, 15)); dct_buffer = DCT_W'($urandom);
      tick();
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", overflow_cnt); end
    checks++; if (rd_data !== exp_head()) begin errors++; $display("FAIL ovf_head: got %h expected %h", rd_data, exp_head()); end
    rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      dct_count = CNT_W'($urandom_range(1, 15)); dct_buffer = DCT_W'($urandom);
      tick();
      checks++; if (level !== 5'd16 || overflow_cnt !== 16'd4) begin errors++;
        $display("FAIL full_pushpop_%0d: got level %0d ovf %0d expected 16 4", i, level, overflow_cnt); end
      checks++; if (rd_data !== exp_head()) begin errors++;
        $display("FAIL full_pushpop_head_%0d: got %h expected %h", i, rd_data, exp_head()); end
    end
    idle_inputs();
  endtask

  task automatic test_ovf_saturate();
    idle_inputs();
    b_reset = 1;
    tick();
    b_reset = 0;
    for (int i = 0; i < 7; i++) begin
      b_dct_valid = 1; b_dct_count = 4'd2; b_dct_buffer = DCT_W'(i);
      tick();
    end
    b_dct_valid = 0;
    checks++; if (b_level !== 2'd2) begin errors++; $display("FAIL sat_level: got %0d expected 2", b_level); end
    checks++; if (b_overflow_cnt !== 2'd3) begin errors++; $display("FAIL sat_ovf: got %0d expected 3", b_overflow_cnt); end
    checks++; if (b_rd_data !== {4'd2, 30'd0}) begin errors++; $display("FAIL sat_head: got %h expected %h", b_rd_data, {4'd2, 30'd0}); end
  endtask

  task automatic test_zero_drain();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      dct_valid = 1; dct_count = 4'd9; dct_buffer = DCT_W'(100 + i);
      tick();
    end
    dct_count = 4'd0;
    tick();
    tick();
    checks++; if (level !== 5'd2 || overflow_cnt !== 16'd0) begin errors++;
      $display("FAIL zero_count: got level %0d ovf %0d expected 2 0", level, overflow_cnt); end
    dct_valid = 0;
    test_ending = 1;
    tick();
    test_ending = 0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_ending: got %0d expected 1", state); end
    test_has_ended = 1;
    tick();
    test_has_ended = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL drain_enter: got %0d expected 2", state); end
    dct_valid = 1; dct_count = 4'd3; dct_buffer = 30'h3ff;
    tick();
    tick();
    dct_valid = 0;
    checks++; if (level !== 5'd2 || state !== 2'd2) begin errors++;
      $display("FAIL drain_ignore_push: got level %0d state %0d expected 2 2", level, state); end
    rd_ready = 1;
    tick();
    checks++; if (state !== 2'd2 || level !== 5'd1) begin errors++;
      $display("FAIL drain_pop1: got state %0d level %0d expected 2 1", state, level); end
    tick();
    checks++; if (state !== 2'd3 || drained !== 1'b1 || level !== 5'd0) begin errors++;
      $display("FAIL drain_done: got state %0d drained %0b level %0d expected 3 1 0", state, drained, level); end
    rd_ready = 0;
    test_ending = 1; test_has_ended = 1;
    tick();
    idle_inputs();
    checks++; if (state !== 2'd3 || drained !== 1'b1) begin errors++;
      $display("FAIL done_hold: got state %0d drained %0b expected 3 1", state, drained); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    test_ending = 1; test_has_ended = 1;
    tick();
    test_ending = 0; test_has_ended = 0;
    checks++; if (state !== 2'd2 || drained !== 1'b0) begin errors++;
      $display("FAIL simul_drain: got state %0d drained %0b expected 2 0", state, drained); end
    tick();
    checks++; if (state !== 2'd3 || drained !== 1'b1) begin errors++;
      $display("FAIL simul_done: got state %0d drained %0b expected 3 1", state, drained); end
    do_reset();
    dct_valid = 1; dct_count = 4'd5; dct_buffer = 30'h2abcdef;
    test_has_ended = 1;
    tick();
    idle_inputs();
    checks++; if (state !== 2'd2 || level !== 5'd1 || rd_data !== {4'd5, 30'h2abcdef}) begin errors++;
      $display("FAIL boundary_capture: got state %0d level %0d data %h expected 2 1 %h",
               state, level, rd_data, {4'd5, 30'h2abcdef}); end
  endtask

  task automatic test_wrap_reset();
    logic [DW-1:0] exp;
    do_reset();
    dct_valid = 1; dct_count = 4'd1; dct_buffer = 30'd0;
    tick();
    rd_ready = 1;
    for (int j = 0; j < 40; j++) begin
      exp = {CNT_W'(j % 15 + 1), DCT_W'(j)};
      checks++; if (rd_data !== exp || level !== 5'd1) begin errors++;
        $display("FAIL wrap_%0d: got data %h level %0d expected %h 1", j, rd_data, level, exp); end
      dct_count = CNT_W'((j + 1) % 15 + 1); dct_buffer = DCT_W'(j + 1);
      tick();
    end
    rd_ready = 0;
    for (int j = 0; j < 17; j++) begin
      dct_count = 4'd4; dct_buffer = DCT_W'(1000 + j);
      tick();
    end
    dct_valid = 0;
    checks++; if (level !== 5'd16 || overflow_cnt !== 16'd2) begin errors++;
      $display("FAIL prefill: got level %0d ovf %0d expected 16 2", level, overflow_cnt); end
    test_has_ended = 1;
    tick();
    test_has_ended = 0;
    rd_ready = 1;
    tick();
    rd_ready = 0;
    checks++; if (state !== 2'd2 || level !== 5'd15) begin errors++;
      $display("FAIL mid_drain: got state %0d level %0d expected 2 15", state, level); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (state !== 2'd0 || level !== 5'd0 || overflow_cnt !== 16'd0 || rd_valid !== 1'b0 ||
                  rd_data !== '0 || drained !== 1'b0) begin errors++;
      $display("FAIL drain_reset: got state %0d level %0d ovf %0d valid %0b data %h drained %0b expected 0 0 0 0 0 0",
               state, level, overflow_cnt, rd_valid, rd_data, drained); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      dct_valid      = ($urandom_range(0, 3) != 0);
      dct_count      = ($urandom_range(0, 7) == 0) ? 4'd0 : CNT_W'($urandom_range(1, 15));
      dct_buffer     = DCT_W'($urandom);
      rd_ready       = ($urandom_range(0, 2) == 0);
      test_ending    = ($urandom_range(0, 49) == 0);
      test_has_ended = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (state !== 2'(m_state) || drained !== (m_state == 3)) begin errors++;
        $display("FAIL rand_state_%0d: got state %0d drained %0b expected %0d", n, state, drained, m_state); end
      checks++; if (level !== 5'(mq.size()) || rd_valid !== (mq.size() != 0)) begin errors++;
        $display("FAIL rand_level_%0d: got level %0d valid %0b expected %0d", n, level, rd_valid, mq.size()); end
      checks++; if (rd_data !== exp_head()) begin errors++;
        $display("FAIL rand_data_%0d: got %h expected %h", n, rd_data, exp_head()); end
      checks++; if (overflow_cnt !== 16'(m_ovf)) begin errors++;
        $display("FAIL rand_ovf_%0d: got %0d expected %0d", n, overflow_cnt, m_ovf); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_push_pop();
    test_overflow();
    test_ovf_saturate();
    test_zero_drain();
    test_simultaneous();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
